// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and constants for the instruction memory loader
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      CSUM,
      FIN
   } state_t;

   localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;
   localparam int          WORD_BYTES = 4;
   localparam int          LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - little-endian byte-to-word packer for the loader
module loader_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [23:0]       sr_q, sr_d;
   logic [LANE_W-1:0] lane_q, lane_d;

   // Only three bytes are stored; the fourth completes the word combinationally.
   assign word_o      = {byte_i, sr_q};
   assign word_full_o = shift_i && (lane_q == LANE_W'(WORD_BYTES - 1));

   always_comb begin
      sr_d   = sr_q;
      lane_d = lane_q;
      if (clear_i) begin
         lane_d = '0;
      end else if (shift_i) begin
         sr_d   = {byte_i, sr_q[23:8]};
         lane_d = lane_q + LANE_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sr_q   <= '0;
         lane_q <= '0;
      end else begin
         sr_q   <= sr_d;
         lane_q <= lane_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte stream to instruction memory loader; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int CNT_W       = 16
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               start,
   input  logic                               byte_valid,
   input  logic [7:0]                         byte_data,
   output logic                               byte_ready,
   output logic                               we,
   output logic [31:0]                        wa,
   output logic [31:0]                        wd,
   output logic                               cpu_hold,
   output logic                               busy,
   output logic                               done,
   output logic [$clog2(DEPTH_WORDS+1)-1:0]   words_written,
   output logic                               err_overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic                               err_checksum
`endif
);

   localparam int                WW_W      = $clog2(DEPTH_WORDS + 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH_WORDS);
   localparam logic [WW_W-1:0]   DEPTH_WW  = WW_W'(DEPTH_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t            END_STATE = CSUM;
`else
   localparam state_t            END_STATE = FIN;
`endif

   state_t            state_q, state_d;
   logic              byte_ready_q, we_q, cpu_hold_q, busy_q, done_q, err_ovf_q;
   logic [31:0]       wa_q, wd_q;
   logic [WW_W-1:0]   ww_q;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  hdr_len;
   logic              xfer, shift, clear, pk_full;
   logic [31:0]       pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
   logic              err_cs_q;
`endif

   assign xfer    = byte_valid && byte_ready_q;
   assign shift   = xfer && (state_q == DATA);
   assign clear   = start && (state_q == IDLE);
   assign hdr_len = CNT_W'({byte_data, len_q[7:0]});

   loader_word_packer u_packer (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .clear_i     (clear),
      .shift_i     (shift),
      .byte_i      (byte_data),
      .word_o      (pk_word),
      .word_full_o (pk_full)
   );

   // len_q counts words still to arrive once the header is in, so zero in WRITE means last word.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = LEN_LO;
         LEN_LO:  if (xfer) state_d = LEN_HI;
         LEN_HI:  if (xfer) state_d = (hdr_len == '0) ? END_STATE : DATA;
         DATA:    if (pk_full) state_d = WRITE;
         WRITE:   state_d = (len_q == '0) ? END_STATE : DATA;
         CSUM:    if (xfer) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         byte_ready_q <= 1'b0;
         we_q         <= 1'b0;
         cpu_hold_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_ovf_q    <= 1'b0;
         wa_q         <= IMEM_BASE;
         wd_q         <= '0;
         ww_q         <= '0;
         len_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
         err_cs_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         byte_ready_q <= state_d inside {LEN_LO, LEN_HI, DATA, CSUM};
         busy_q       <= !(state_d inside {IDLE, FIN});
         cpu_hold_q   <= !(state_d inside {IDLE, FIN});
         done_q       <= (state_d == FIN);
         we_q         <= 1'b0;

         if (clear) begin
            ww_q      <= '0;
            wa_q      <= IMEM_BASE;
            err_ovf_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
            err_cs_q  <= 1'b0;
`endif
         end

         if (state_q == LEN_LO && xfer) len_q <= CNT_W'(byte_data);
         if (state_q == LEN_HI && xfer) begin
            len_q     <= hdr_len;
            err_ovf_q <= (hdr_len > DEPTH_CNT);
         end

         // Words past the memory end are still drained from the stream, just not written.
         if (pk_full) begin
            len_q <= len_q - CNT_W'(1);
            wd_q  <= pk_word;
            we_q  <= (ww_q < DEPTH_WW);
         end

         if (we_q) begin
            wa_q <= wa_q + 32'(WORD_BYTES);
            ww_q <= ww_q + WW_W'(1);
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         if (shift) csum_q <= csum_q ^ byte_data;
         if (state_q == CSUM && xfer) err_cs_q <= (byte_data != csum_q);
`endif
      end
   end

   assign byte_ready    = byte_ready_q;
   assign we            = we_q;
   assign wa            = wa_q;
   assign wd            = wd_q;
   assign cpu_hold      = cpu_hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign words_written = ww_q;
   assign err_overflow  = err_ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign err_checksum  = err_cs_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset_n, start, byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, we, cpu_hold, busy, done, err_overflow;
   logic [31:0] wa, wd;
   logic [10:0] words_written;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic        err_checksum;
`endif

   int tests = 0;
   int fails = 0;

   int          we_cnt = 0;
   int          done_cnt = 0;
   logic [31:0] wa_log[$];
   logic [31:0] wd_log[$];
   logic        in_session = 1'b0;
   int          hold_gap = 0;
   int          hold_at_done = 0;

   imem_loader dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .we            (we),
      .wa            (wa),
      .wd            (wd),
      .cpu_hold      (cpu_hold),
      .busy          (busy),
      .done          (done),
      .words_written (words_written),
      .err_overflow  (err_overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .err_checksum  (err_checksum)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we === 1'b1) begin
         we_cnt = we_cnt + 1;
         wa_log.push_back(wa);
         wd_log.push_back(wd);
      end
      if (done === 1'b1) done_cnt = done_cnt + 1;
      if (in_session && cpu_hold !== 1'b1 && done !== 1'b1) hold_gap = hold_gap + 1;
      if (done === 1'b1 && cpu_hold !== 1'b0) hold_at_done = hold_at_done + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      while (byte_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (byte_ready !== 1'b1) begin
         tests++; fails++;
         $display("FAIL send_byte_timeout: byte %02h ready=%b required 1", b, byte_ready);
      end
      @(posedge clk);
      #1 byte_valid = 1'b0;
   endtask

   task automatic start_session();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      in_session = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL %s_done: done=%b required 1", name, done);
      end
      tests++;
      if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
         fails++;
         $display("FAIL %s_release: busy=%b cpu_hold=%b required 0 0 in done cycle", name, busy, cpu_hold);
      end
      in_session = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({byte_ready, we, cpu_hold, busy, done, err_overflow} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b required 000000",
                  {byte_ready, we, cpu_hold, busy, done, err_overflow});
      end
      tests++;
      if (wa !== 32'h0 || wd !== 32'h0 || words_written !== 11'd0) begin
         fails++;
         $display("FAIL reset_regs: wa=%h wd=%h ww=%0d required 0 0 0", wa, wd, words_written);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_single_word();
      int w0 = we_cnt;
      int d0 = done_cnt;
      // start together with a valid byte: the IDLE cycle must not consume it
      @(negedge clk);
      start = 1'b1; byte_valid = 1'b1; byte_data = 8'h01;
      @(posedge clk);
      #1 start = 1'b0;
      in_session = 1'b1;
      tests++;
      if (busy !== 1'b1 || cpu_hold !== 1'b1 || words_written !== 11'd0) begin
         fails++;
         $display("FAIL single_start: busy=%b hold=%b ww=%0d required 1 1 0", busy, cpu_hold, words_written);
      end
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h08);
`endif
      wait_done("single");
      tests++;
      if (we_cnt - w0 !== 1) begin
         fails++;
         $display("FAIL single_we_count: got %0d required 1", we_cnt - w0);
      end else begin
         tests++;
         if (wa_log[w0] !== 32'h0 || wd_log[w0] !== 32'h1234_5678) begin
            fails++;
            $display("FAIL single_write: wa=%h wd=%h required 00000000 12345678", wa_log[w0], wd_log[w0]);
         end
      end
      tests++;
      if (words_written !== 11'd1) begin
         fails++;
         $display("FAIL single_ww: got %0d required 1", words_written);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || done_cnt - d0 !== 1) begin
         fails++;
         $display("FAIL single_done_pulse: done=%b pulses=%0d required 0 1", done, done_cnt - d0);
      end
   endtask

   task automatic test_three_words();
      logic [7:0]  d [12];
      logic [31:0] exp_wd [3];
      int w0;
      d = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      exp_wd = '{32'h1122_3344, 32'hA5A5_0001, 32'hDEAD_BEEF};
      w0 = we_cnt;
      hold_gap = 0;
      hold_at_done = 0;
      start_session();
      send_byte(8'h03);
      send_byte(8'h00);
      for (int i = 0; i < 12; i++) begin
         send_byte(d[i]);
         if (i == 5) begin
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h67);
`endif
      wait_done("three");
      tests++;
      if (we_cnt - w0 !== 3) begin
         fails++;
         $display("FAIL three_we_count: got %0d required 3", we_cnt - w0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (wa_log[w0+i] !== 32'(i * 4) || wd_log[w0+i] !== exp_wd[i]) begin
               fails++;
               $display("FAIL three_write%0d: wa=%h wd=%h required %h %h",
                        i, wa_log[w0+i], wd_log[w0+i], 32'(i * 4), exp_wd[i]);
            end
         end
      end
      tests++;
      if (hold_gap !== 0 || hold_at_done !== 0) begin
         fails++;
         $display("FAIL three_hold: gaps=%0d hold_in_done=%0d required 0 0", hold_gap, hold_at_done);
      end
      tests++;
      if (words_written !== 11'd3) begin
         fails++;
         $display("FAIL three_ww: got %0d required 3", words_written);
      end
   endtask

   task automatic test_overflow();
      int w0 = we_cnt;
      logic [7:0] cs = 8'h00;
      logic [31:0] v;
      start_session();
      send_byte(8'h01);
      send_byte(8'h04);
      tests++;
      if (err_overflow !== 1'b1) begin
         fails++;
         $display("FAIL ovf_flag: got %b required 1", err_overflow);
      end
      for (int i = 0; i < 1025; i++) begin
         v = 32'(i);
         for (int b = 0; b < 4; b++) begin
            cs = cs ^ v[8*b +: 8];
            send_byte(v[8*b +: 8]);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs);
`endif
      wait_done("ovf");
      tests++;
      if (we_cnt - w0 !== 1024) begin
         fails++;
         $display("FAIL ovf_we_count: got %0d required 1024", we_cnt - w0);
      end else begin
         tests++;
         if (wa_log[w0+1023] !== 32'h0000_0FFC || wd_log[w0+1023] !== 32'd1023) begin
            fails++;
            $display("FAIL ovf_last_write: wa=%h wd=%h required 00000ffc 000003ff",
                     wa_log[w0+1023], wd_log[w0+1023]);
         end
      end
      tests++;
      if (words_written !== 11'd1024 || err_overflow !== 1'b1) begin
         fails++;
         $display("FAIL ovf_final: ww=%0d ovf=%b required 1024 1", words_written, err_overflow);
      end
   endtask

   task automatic test_zero_len();
      int w0 = we_cnt;
      start_session();
      tests++;
      if (err_overflow !== 1'b0 || words_written !== 11'd0) begin
         fails++;
         $display("FAIL zero_start_clear: ovf=%b ww=%0d required 0 0", err_overflow, words_written);
      end
      send_byte(8'h00);
      send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h00);
`endif
      wait_done("zero");
      tests++;
      if (we_cnt - w0 !== 0 || err_overflow !== 1'b0) begin
         fails++;
         $display("FAIL zero_result: writes=%0d ovf=%b required 0 0", we_cnt - w0, err_overflow);
      end
   endtask

   task automatic test_reset_mid();
      int w0 = we_cnt;
      start_session();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      @(negedge clk);
      reset_n = 1'b0;
      in_session = 1'b0;
      #1;
      tests++;
      if ({byte_ready, we, cpu_hold, busy, done, err_overflow} !== 6'b0 ||
          wa !== 32'h0 || wd !== 32'h0 || words_written !== 11'd0) begin
         fails++;
         $display("FAIL midreset_outputs: flags=%b wa=%h wd=%h ww=%0d required 0",
                  {byte_ready, we, cpu_hold, busy, done, err_overflow}, wa, wd, words_written);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tests++;
      if (we_cnt - w0 !== 0) begin
         fails++;
         $display("FAIL midreset_no_write: writes=%0d required 0", we_cnt - w0);
      end
      w0 = we_cnt;
      start_session();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h0D);
      send_byte(8'hF0);
      send_byte(8'hFE);
      send_byte(8'hCA);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'hC9);
`endif
      wait_done("reload");
      tests++;
      if (we_cnt - w0 !== 1) begin
         fails++;
         $display("FAIL reload_we_count: got %0d required 1", we_cnt - w0);
      end else begin
         tests++;
         if (wa_log[w0] !== 32'h0 || wd_log[w0] !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL reload_write: wa=%h wd=%h required 00000000 cafef00d", wa_log[w0], wd_log[w0]);
         end
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] csb [2];
      logic       exp_err [2];
      csb     = '{8'hFF, 8'h00};
      exp_err = '{1'b0, 1'b1};
      for (int k = 0; k < 2; k++) begin
         start_session();
         send_byte(8'h01);
         send_byte(8'h00);
         send_byte(8'hFF);
         send_byte(8'h00);
         send_byte(8'h00);
         send_byte(8'h00);
         send_byte(csb[k]);
         wait_done("csum");
         tests++;
         if (err_checksum !== exp_err[k]) begin
            fails++;
            $display("FAIL csum_%0d: err_checksum=%b required %b", k, err_checksum, exp_err[k]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_three_words();
      test_overflow();
      test_zero_len();
      test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
